serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised bit-serial adder. Next generation of the team's single-bit half-adder cell.
- Accepts two WIDTH-bit operands and a carry-in on a start pulse, then adds one bit per clock, LSB first, through a single full-adder cell.
- Presents registered sum and carry-out with a done pulse.
- Area-cheap arithmetic unit for slow datapaths and teaching benches.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; sum/cout valid from this cycle
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out, held until next completion

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, immediate, no clock needed):
  - state=IDLE, busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry register and bit counter = 0
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: start=1 at a rising edge:
  - a, b load into shift registers; carry register = cin; counter = 0
  - next state RUN (busy=1 next cycle)
  - start=0: remain in IDLE.
- RUN, each edge:
  - full-add a_sh[0], b_sh[0], carry
  - sum bit shifts into MSB of the partial-sum register (right shift)
  - a_sh, b_sh shift right; carry register = carry-out; counter += 1
  - at the edge where counter == WIDTH-1: sum <= completed partial sum, cout <= final carry, next state DONE
- DONE, lasts exactly one cycle:
  - done=1, busy=0
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back ops, no bubble); otherwise go to IDLE.
- Latency: start sampled at edge 0 -> done high after edge WIDTH. Throughput: one result per WIDTH+1 cycles.
- start while in RUN is ignored; operand inputs are don't-care outside the accepting edge.
- sum/cout change only on entry to DONE; they are never partial values.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Counter width: $clog2(WIDTH).
- Reset mid-RUN aborts the operation: outputs return to reset values, and the previous result is lost.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - extra input port sub (1 bit), captured with the operands
  - sub=1: b_sh is loaded with ~b and carry register with 1 (cin ignored), so result = a - b
  - cout=1 means no borrow
- Undefined: no sub port; addition only.

Decomposition:
- Package serial_adder_pkg:
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}
  - localparam for state encoding widths
- Sub-module full_adder_cell:
  - combinational full adder built from two dataflow half adders plus an OR for carry
  - instanced once in serial_adder

Test Plan (WIDTH=8):
- Assert rst_n=0 -> busy=0, done=0, sum=8'h00, cout=0 immediately, without a clock edge.
- a=8'h0F, b=8'h01, cin=0, start pulse -> busy high 8 cycles, done pulse after edge 8, sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start held high through RUN with different operands -> ignored. start high in the DONE cycle with a=8'h03, b=8'h04 -> new op accepted with no idle cycle; next done gives sum=8'h07, sum holds the previous result until then.
- rst_n low at RUN edge 4 -> all outputs zero, state IDLE. Afterwards a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
- SERIAL_ADDER_SUB_EN: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0. a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from two dataflow half adders and an OR for the carry.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    // First half adder combines the operand bits, second folds in the carry.
    assign s1 = x ^ y;
    assign c1 = x & y;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit a + b + cin, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input for a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] psum_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cout=1 then means no borrow.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    full_adder_cell u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_bit)
    );

    assign psum_nxt = {s_bit, psum[WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            psum  <= psum_nxt;
            carry <= c_bit;
            cnt   <= cnt + CNT_W'(1);
            // Publish only the completed word so sum/cout never show partials.
            if (cnt == LAST_CNT) begin
                sum  <= psum_nxt;
                cout <= c_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub   = 1'b0;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the result currently held on sum/cout.
    logic [WIDTH-1:0] exp_sum  = '0;
    logic             exp_cout = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .sub   (sub)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                   input logic c, input logic s);
        int r;
        if (s) r = int'(x) + (1 << WIDTH) - int'(y);
        else   r = int'(x) + int'(y) + int'(c);
        return (WIDTH+1)'(r);
    endfunction

    // Starts an operation from a negedge where the DUT is IDLE or DONE and returns
    // at the negedge where done must be high. hold keeps start high with junk operands.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                          input logic ts, input logic hold, input string name);
        logic [WIDTH:0] r;
        r = ref_result(ta, tb_, tc, ts);
        a = ta; b = tb_; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`endif
        @(negedge clk);
        start = hold;
        for (int k = 0; k < WIDTH; k++) begin
            n_cmp++;
            if ({busy, done, cout, sum} !== {2'b10, exp_cout, exp_sum}) begin
                n_err++;
                $display("FAIL %s run%0d: busy/done/cout/sum got %b/%b/%b/%h want 1/0/%b/%h",
                         name, k, busy, done, cout, sum, exp_cout, exp_sum);
            end
            if (hold) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            end
            @(negedge clk);
        end
        {exp_cout, exp_sum} = r;
        n_cmp++;
        if ({busy, done, cout, sum} !== {2'b01, exp_cout, exp_sum}) begin
            n_err++;
            $display("FAIL %s done: busy/done/cout/sum got %b/%b/%b/%h want 0/1/%b/%h",
                     name, busy, done, cout, sum, exp_cout, exp_sum);
        end
        start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if ({busy, done, cout, sum} !== {2'b00, exp_cout, exp_sum}) begin
            n_err++;
            $display("FAIL %s idle: busy/done/cout/sum got %b/%b/%b/%h want 0/0/%b/%h",
                     name, busy, done, cout, sum, exp_cout, exp_sum);
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        exp_sum = '0; exp_cout = 1'b0;
        check_idle("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset_hold");
    endtask

    task automatic test_basic();
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, "add_0f_01");
        @(negedge clk);
        check_idle("done_one_cycle");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "add_ff_01");
        @(negedge clk);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, "add_ff_ff_c");
        @(negedge clk);
        check_idle("after_ff_ff");
    endtask

    task automatic test_back_to_back();
        run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 1'b1, "start_held");
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, "b2b_03_04");
    endtask

    task automatic test_reset_mid_run();
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_sum = '0; exp_cout = 1'b0;
        check_idle("abort_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("abort_idle");
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, "add_80_80");
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic ts;
            ts = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ts = 1'($urandom);
`endif
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), ts, 1'($urandom), "random");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_idle("random_gap");
            end
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, "sub_05_07");
        run_op(8'h07, 8'h05, 1'b1, 1'b1, 1'b0, "sub_07_05");
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
